// File: rtl/vga_decoder.sv
// Receive-side VGA timing checker: locks to hsync/vsync, flags any
// timing violation and recovers the split-screen colour code per frame.
module vga_decoder #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_TOTAL     = 800,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_LINES  = 4,
  parameter int SAMPLE_LINE = 240
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  red,
  input  logic [3:0]  green,
  input  logic [3:0]  blue,
  output logic [23:0] code,
  output logic        code_valid,
  output logic        locked,
  output logic        timing_err
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int GW = $clog2(LOCK_LINES + 1);

  localparam logic [HW-1:0] HS_FALL = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] HS_NEXT = HW'(H_VISIBLE + H_FRONT + 1);
  localparam logic [HW-1:0] HS_RISE = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS   = HW'(H_VISIBLE);
  localparam logic [HW-1:0] CAP_L   = HW'(H_VISIBLE / 4);
  localparam logic [HW-1:0] CAP_R   = HW'(3 * H_VISIBLE / 4);
  localparam logic [VW-1:0] VS_FALL = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] VS_RISE = VW'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS   = VW'(V_VISIBLE);
  localparam logic [VW-1:0] V_SAMP  = VW'(SAMPLE_LINE);
  localparam logic [GW-1:0] G_MAX   = GW'(LOCK_LINES);

  typedef enum logic [1:0] {
    SEARCH,
    H_TRACK,
    V_WAIT,
    LOCKED
  } state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] h_cnt, h_nxt, h_inc;
  logic [VW-1:0] v_cnt, v_nxt, v_inc;
  logic [GW-1:0] good_lines, good_nxt;
  logic          prev_h, prev_v;
  logic          cap_l, cap_l_nxt;
  logic          cap_r, cap_r_nxt;
  logic [11:0]   left_s, left_nxt;
  logic [11:0]   right_s, right_nxt;
  logic [23:0]   code_nxt;
  logic          valid_nxt, err_nxt;

  logic [11:0] rgb;
  logic        h_fall, h_rise, v_fall, v_rise;
  logic        h_wrap, at_vf, at_vr;
  logic        h_bad, h_miss, v_bad, rgb_bad, lock_bad;

  assign rgb    = {red, green, blue};
  assign h_fall = prev_h & ~hsync;
  assign h_rise = ~prev_h & hsync;
  assign v_fall = prev_v & ~vsync;
  assign v_rise = ~prev_v & vsync;

  assign h_wrap = (h_cnt == H_LAST);
  assign h_inc  = h_wrap ? '0 : h_cnt + 1'b1;
  assign v_inc  = !h_wrap ? v_cnt :
                  (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;

  assign at_vf = (h_cnt == '0) && (v_cnt == VS_FALL);
  assign at_vr = (h_cnt == '0) && (v_cnt == VS_RISE);

  assign h_bad   = (h_fall && h_cnt != HS_FALL)
                || (h_rise && h_cnt != HS_RISE);
  assign h_miss  = (h_cnt == HS_FALL && !h_fall)
                || (h_cnt == HS_RISE && !h_rise);
  assign v_bad   = (v_fall != at_vf) || (v_rise != at_vr);
  assign rgb_bad = (rgb != '0)
                && (h_cnt >= H_VIS || v_cnt >= V_VIS);

  assign lock_bad = h_bad | h_miss | v_bad | rgb_bad;

  assign locked = (state == LOCKED);

  always_comb begin
    state_nxt = state;
    h_nxt     = h_inc;
    v_nxt     = v_inc;
    good_nxt  = good_lines;
    cap_l_nxt = cap_l;
    cap_r_nxt = cap_r;
    left_nxt  = left_s;
    right_nxt = right_s;
    code_nxt  = code;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    unique case (state)
      SEARCH: begin
        if (h_fall) begin
          h_nxt     = HS_NEXT;
          good_nxt  = '0;
          state_nxt = H_TRACK;
        end
      end
      H_TRACK, V_WAIT: begin
        if (h_bad) begin
          err_nxt   = 1'b1;
          state_nxt = SEARCH;
        end else begin
          if (h_fall && good_lines != G_MAX)
            good_nxt = good_lines + 1'b1;
          if (state == H_TRACK && good_lines == G_MAX)
            state_nxt = V_WAIT;
          // lock event anchors the vertical count; no code yet
          if (state == V_WAIT && v_fall && h_cnt == '0) begin
            v_nxt     = VS_FALL;
            cap_l_nxt = 1'b0;
            cap_r_nxt = 1'b0;
            state_nxt = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (lock_bad) begin
          err_nxt   = 1'b1;
          cap_l_nxt = 1'b0;
          cap_r_nxt = 1'b0;
          state_nxt = SEARCH;
        end else begin
          if (v_fall) begin
            if (cap_l && cap_r) begin
              code_nxt  = {left_s, right_s};
              valid_nxt = 1'b1;
            end
            cap_l_nxt = 1'b0;
            cap_r_nxt = 1'b0;
          end
          if (v_cnt == V_SAMP && h_cnt == CAP_L) begin
            left_nxt  = rgb;
            cap_l_nxt = 1'b1;
          end
          if (v_cnt == V_SAMP && h_cnt == CAP_R) begin
            right_nxt = rgb;
            cap_r_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SEARCH;
      h_cnt      <= '0;
      v_cnt      <= '0;
      good_lines <= '0;
      prev_h     <= 1'b1;
      prev_v     <= 1'b1;
      cap_l      <= 1'b0;
      cap_r      <= 1'b0;
      left_s     <= '0;
      right_s    <= '0;
      code       <= '0;
      code_valid <= 1'b0;
      timing_err <= 1'b0;
    end else begin
      state      <= state_nxt;
      h_cnt      <= h_nxt;
      v_cnt      <= v_nxt;
      good_lines <= good_nxt;
      prev_h     <= hsync;
      prev_v     <= vsync;
      cap_l      <= cap_l_nxt;
      cap_r      <= cap_r_nxt;
      left_s     <= left_nxt;
      right_s    <= right_nxt;
      code       <= code_nxt;
      code_valid <= valid_nxt;
      timing_err <= err_nxt;
    end
  end

endmodule
